matrix_column_scanner: RTL
==========================

// Module: matrix_column_scanner
// PURPOSE
//   Scan sequencer that drives the 5x7 LED-matrix column multiplexer.
//   - Holds the 35-bit frame shown on the display and outputs it as frame_out (35b) to the mux data input.
//   - Generates the 3-bit column select sel_out (1..7) and the active-low column enables col_n.
//   - Takes new frames through a valid/ready handshake into a pending buffer.
//   - Copies the pending frame into the displayed frame only at the end of a frame, so a partly drawn frame is never shown.
// PARAMETERS
//   DWELL_CYCLES  50000  clk cycles each column stays selected (>=2)
//   BLANK_CYCLES  4      blanking cycles at end of each dwell, only with MATRIX_BLANK_EN (< DWELL_CYCLES)
// PORTS
//   clk          in   1   single system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   scan_en      in   1   1 = scanning runs; 0 = scan frozen, display dark
//   load_data    in   35  new frame: bits [34:28] row4 ... [6:0] row0
//   load_valid   in   1   load_data is valid this cycle
//   load_ready   out  1   pending buffer empty, can accept a frame
//   frame_out    out  35  displayed frame, goes to the mux data input
//   sel_out      out  3   column select, goes to the mux sel input
//   col_n        out  7   active-low column enables; bit k means column k+1
//   frame_start  out  1   1-cycle pulse when the column wraps from 7 to 1
// BEHAVIOUR
//   Reset (async, applies immediately) sets:
//     frame_out=0, sel_out=3'd1, col_n=7'h7F, frame_start=0, dwell counter=0, pending empty, load_ready=1.
//   Dwell counter:
//     width $clog2(DWELL_CYCLES); counts 0..DWELL_CYCLES-1; advances only while scan_en=1.
//   Column step: when the counter equals DWELL_CYCLES-1 and scan_en=1:
//     - counter goes back to 0;
//     - sel_out steps 1,2,..,7, then wraps to 1;
//     - sel_out never takes 0 or values above 7.
//   Frame boundary: the step from 7 to 1. On the same clock edge:
//     - frame_start=1 for one cycle;
//     - if the pending buffer is full, the pending frame is copied to frame_out and the buffer is cleared.
//   col_n:
//     - registered, updated on the same edge as sel_out;
//     - equals ~(7'b1 << (sel_out-1)) while scan_en=1;
//     - equals 7'h7F when scan_en=0 or during reset;
//     - exactly one bit is low at a time.
//   Handshake:
//     - A load is captured when load_valid=1 and load_ready=1.
//     - The next cycle load_ready=0, until the next frame swap.
//     - load_valid is allowed while load_ready=0; it is ignored and no data is lost or partly written.
//     - If a load is captured in the same cycle as the frame swap (buffer was empty), the swap sees an empty buffer.
//       frame_out keeps its value, and the new frame is shown at the following boundary.
//     - If the swap and a new capture fall on the same edge, the buffer ends up full with the new data.
//   scan_en=0:
//     - counter and sel_out hold their values; col_n=7'h7F; frame_start=0;
//     - loads are still accepted, but no swap happens.
//     - When scan_en returns to 1, the held column finishes its remaining dwell cycles.
//   Reset mid-frame: the pending frame is dropped and scanning restarts at column 1, counter 0.
//   Latency from scan_en rising to the first low col_n bit: 1 clk.
// CONFIGURATION
//   MATRIX_BLANK_EN defined:
//     - col_n=7'h7F during the last BLANK_CYCLES counts of each dwell (counter >= DWELL_CYCLES-BLANK_CYCLES);
//     - sel_out and frame_out are unchanged; this suppresses ghosting between columns.
//   MATRIX_BLANK_EN not defined:
//     - no blanking; col_n is active for the whole dwell; BLANK_CYCLES is unused.
// TESTING (DWELL_CYCLES=4, BLANK_CYCLES=1)
//   1. Reset asserted mid-scan, then released with scan_en=1:
//      - while in reset: sel_out=1, col_n=7F, frame_out=0, load_ready=1;
//      - 1 clk after release: col_n=7E.
//   2. Free-run 28 clk:
//      - sel_out goes 1..7 with 4 clk per column; col_n goes 7E,7D,7B,77,6F,5F,3F;
//      - then wraps to sel_out=1 with frame_start high for exactly 1 clk.
//   3. Load 35'h5_5555_5555 while sel_out=3:
//      - load_ready=0 the next clk; frame_out stays 0 until the 7->1 step;
//      - after that step frame_out=35'h5_5555_5555 and load_ready=1.
//   4. Second load_valid while load_ready=0, data 35'h7_FFFF_FFFF:
//      - ignored; the frame after the swap is the first load's data.
//   5. scan_en=0 for 10 clk at sel_out=5, counter=2:
//      - col_n=7F; sel_out holds at 5;
//      - after scan_en=1, column 5 stays 2 more clk, then sel_out=6.
//   6. MATRIX_BLANK_EN defined, one column dwell observed:
//      - col_n active for 3 clk, then 7F for 1 clk, then the next column.

Source files
------------

// File: rtl/matrix_column_scanner.sv
// ============================================================================
// matrix_column_scanner
// ----------------------------------------------------------------------------
// Scan sequencer for a 5x7 LED-matrix column multiplexer.
//   - Holds the displayed 35-bit frame and presents it on frame_out.
//   - Steps the column select sel_out through 1..7, one column every
//     DWELL_CYCLES clocks, and drives registered active-low enables col_n.
//   - Accepts new frames through a valid/ready handshake into a one-entry
//     pending buffer. The buffer is copied to the display only at the 7->1
//     frame boundary, so a half-drawn frame is never shown.
//
// Optional build macro:
//   MATRIX_BLANK_EN  blank col_n during the last BLANK_CYCLES counts of each
//                    column dwell to suppress ghosting between columns.
//
// Parameters:
//   DWELL_CYCLES  clocks each column stays selected (>= 2)
//   BLANK_CYCLES  blanking clocks at the end of each dwell (< DWELL_CYCLES),
//                 used only with MATRIX_BLANK_EN
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   scan_en      in   1 = scanning runs; 0 = scan frozen, display dark
//   load_data    in   new frame, [34:28] row4 ... [6:0] row0
//   load_valid   in   load_data valid this cycle
//   load_ready   out  pending buffer empty, a frame can be accepted
//   frame_out    out  displayed frame, to the mux data input
//   sel_out      out  column select 1..7, to the mux sel input
//   col_n        out  active-low column enables, bit k = column k+1
//   frame_start  out  one-cycle pulse after the 7->1 column wrap
// ============================================================================
module matrix_column_scanner #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [34:0] load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [34:0] frame_out,
    output logic [2:0]  sel_out,
    output logic [6:0]  col_n,
    output logic        frame_start
);

    localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DWELL_CYCLES - 1);

    // Reject configurations where the dwell/blank arithmetic breaks down.
    if (DWELL_CYCLES < 2 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_params
        $error("matrix_column_scanner: need DWELL_CYCLES >= 2 and BLANK_CYCLES < DWELL_CYCLES");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    sel_d;
    logic [6:0]    col_n_d;
    logic          col_step;
    logic          frame_wrap;
    logic          blank_d;
    logic          pend_full;
    logic [34:0]   pend_data;
    logic          capture;
    logic          swap;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        // NOTE: blocking '=' in combinational logic, '<=' only in clocked blocks.
        cnt_d      = cnt_q;
        sel_d      = sel_out;
        col_step   = scan_en && (cnt_q == LAST_COUNT);
        frame_wrap = col_step && (sel_out == 3'd7);

        if (scan_en) begin
            cnt_d = col_step ? '0 : cnt_q + 1'b1;
        end
        if (col_step) begin
            sel_d = frame_wrap ? 3'd1 : sel_out + 3'd1;
        end
    end

    // col_n is registered from the *next* column/count, so it changes on the
    // same edge as sel_out and lights up one clock after scan_en rises.
`ifdef MATRIX_BLANK_EN
    localparam logic [CW-1:0] BLANK_START = CW'(DWELL_CYCLES - BLANK_CYCLES);
    assign blank_d = (cnt_d >= BLANK_START);
`else
    assign blank_d = 1'b0;
`endif

    assign col_n_d = (scan_en && !blank_d) ? ~(7'd1 << (sel_d - 3'd1)) : 7'h7F;

    // Handshake: capture needs an empty buffer and swap needs a full one, so
    // they never coincide. A capture on the wrap edge lands after the swap
    // decision and is shown at the following boundary.
    assign load_ready = !pend_full;
    assign capture    = load_valid && !pend_full;
    assign swap       = frame_wrap && pend_full;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            sel_out     <= 3'd1;
            col_n       <= 7'h7F;
            frame_start <= 1'b0;
            frame_out   <= '0;
            pend_full   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_out     <= sel_d;
            col_n       <= col_n_d;
            frame_start <= frame_wrap;
            if (swap) begin
                frame_out <= pend_data;
            end
            if (capture) begin
                pend_full <= 1'b1;
            end else if (swap) begin
                pend_full <= 1'b0;
            end
        end
    end

    // NOTE: the pending data register carries no reset; pend_full qualifies
    // it, so its contents are never observed before a capture writes it.
    always_ff @(posedge clk) begin
        if (capture) begin
            pend_data <= load_data;
        end
    end

endmodule
